// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : UART-wide constants and the transmit-FIFO launcher state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_W    = 8;
    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115_200;

    // Launcher states: IDLE waits for data, LOAD is the tx_start cycle,
    // WAIT holds the byte until the transmitter reports completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x DATA_W storage array, synchronous write port and
//               combinational read port. Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: store the byte on the edge the push is accepted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit byte buffer. Circular FIFO filled at clock rate and
//               drained one byte at a time into the UART transmitter using a
//               one-cycle tx_start, waiting for tx_done between bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              tx_start,
    output logic [DATA_W-1:0] data_out,
    input  logic              tx_done,
    output logic              busy
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    tx_state_e         state_q,    state_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign w_push = wr_en && (count_q != FULL_COUNT);
    assign w_pop  = (state_q == IDLE) && (count_q != '0);

    fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (w_rd_data)
    );

    // Next-state: pointers, occupancy, sticky overflow and launcher FSM.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        data_out_d = data_out_q;
        tx_start_d = w_pop;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = w_rd_data;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A dropped push outranks a simultaneous clear.
        if (wr_en && (count_q == FULL_COUNT)) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            IDLE:    if (w_pop)   state_d = LOAD;
            LOAD:                 state_d = WAIT;
            WAIT:    if (tx_done) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // State registers; reset discards queued and in-flight bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            data_out_q <= data_out_d;
        end
    end

    assign count    = count_q;
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign data_out = data_out_q;
    assign busy     = (state_q == LOAD) || (state_q == WAIT);

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with a byte scoreboard
//               and a simple transmitter model answering with tx_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int DONE_DLY = 10;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             empty;
    logic [ADDR_W:0]  count;
    logic             overflow;
    logic             clr_ovf;
    logic             tx_start;
    logic [7:0]       data_out;
    logic             tx_done;
    logic             busy;

    logic [7:0] exp_q [$];
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         n_starts  = 0;
    int         spur_cnt  = 0;
    int         spur_seen = 0;
    int         cd        = 0;
    bit         auto_done = 0;
    logic       prev_start;
    int         s0;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx_start (tx_start),
        .data_out (data_out),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one push for one clock; the scoreboard takes it only if the
    // model says there is room (stored bytes exclude the one in flight).
    task automatic push_byte(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (!busy && empty) ok = 1;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // Launch monitor: every tx_start pops the scoreboard.
    initial begin
        prev_start = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                n_starts++;
                check("start_width", {31'd0, prev_start}, 32'd0);
                check("start_has_data", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
            prev_start = tx_start;
        end
    end

    // Transmitter model: optional automatic completion DONE_DLY cycles after
    // a launch, plus single manual pulses requested by bumping spur_cnt.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (!reset) begin
                cd = 0;
            end else if (spur_seen != spur_cnt) begin
                tx_done   = 1'b1;
                spur_seen = spur_cnt;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end else if (tx_start && auto_done) begin
                cd = DONE_DLY;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_count",    {27'd0, count},    32'd0);
        check("rst_empty",    {31'd0, empty},    32'd1);
        check("rst_full",     {31'd0, full},     32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte: exact latency and busy span.
        push_byte(8'hA5);
        check("t1_count_e0", {27'd0, count},    32'd1);
        check("t1_start_e0", {31'd0, tx_start}, 32'd0);
        check("t1_busy_e0",  {31'd0, busy},     32'd0);
        @(negedge clk);
        check("t1_start_e1", {31'd0, tx_start}, 32'd1);
        check("t1_data_e1",  {24'd0, data_out}, 32'hA5);
        check("t1_count_e1", {27'd0, count},    32'd0);
        check("t1_busy_e1",  {31'd0, busy},     32'd1);
        @(negedge clk);
        check("t1_start_e2", {31'd0, tx_start}, 32'd0);
        check("t1_busy_e2",  {31'd0, busy},     32'd1);
        check("t1_data_e2",  {24'd0, data_out}, 32'hA5);
        repeat (3) @(negedge clk);
        check("t1_busy_wait", {31'd0, busy}, 32'd1);
        spur_cnt++;
        @(negedge clk);
        check("t1_busy_pre_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_busy_post_done", {31'd0, busy}, 32'd0);
        check("t1_data_hold",      {24'd0, data_out}, 32'hA5);

        // Burst of 20 in two rounds, pointers wrap.
        auto_done = 1;
        s0 = n_starts;
        for (int i = 0; i < 12; i++) push_byte(8'(i));
        wait_idle("t2_idle1");
        for (int i = 12; i < 20; i++) push_byte(8'(i));
        wait_idle("t2_idle2");
        check("t2_starts", n_starts - s0, 32'd20);
        check("t2_count",  {27'd0, count}, 32'd0);

        // Full and overflow with the transmitter stalled.
        auto_done = 0;
        s0 = n_starts;
        for (int i = 0; i < 17; i++) push_byte(8'h40 + 8'(i));
        check("t3_count_full", {27'd0, count},    32'd16);
        check("t3_full",       {31'd0, full},     32'd1);
        check("t3_ovf_before", {31'd0, overflow}, 32'd0);
        push_byte(8'h51);
        check("t3_ovf_set",    {31'd0, overflow}, 32'd1);
        check("t3_count_drop", {27'd0, count},    32'd16);
        @(negedge clk);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        push_byte(8'hEE);
        clr_ovf = 1'b0;
        check("t3_ovf_set_wins", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        auto_done = 1;
        spur_cnt++;
        wait_idle("t3_drain");
        check("t3_starts", n_starts - s0, 32'd17);

        // Simultaneous push and pop with five stored, FSM idle.
        auto_done = 0;
        s0 = n_starts;
        for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
        check("t4_count_wait", {27'd0, count}, 32'd5);
        check("t4_busy_wait",  {31'd0, busy},  32'd1);
        spur_cnt++;
        repeat (2) @(negedge clk);
        check("t4_idle",     {31'd0, busy},  32'd0);
        check("t4_count_id", {27'd0, count}, 32'd5);
        push_byte(8'h66);
        check("t4_count_same", {27'd0, count},    32'd5);
        check("t4_start",      {31'd0, tx_start}, 32'd1);
        auto_done = 1;
        spur_cnt++;
        wait_idle("t4_drain");
        check("t4_starts", n_starts - s0, 32'd7);

        // Asynchronous reset while waiting with three queued.
        auto_done = 0;
        for (int i = 0; i < 4; i++) push_byte(8'h90 + 8'(i));
        check("t5_count", {27'd0, count}, 32'd3);
        check("t5_busy",  {31'd0, busy},  32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_start", {31'd0, tx_start}, 32'd0);
        check("t5_rst_data",  {24'd0, data_out}, 32'h00);
        check("t5_rst_count", {27'd0, count},    32'd0);
        check("t5_rst_empty", {31'd0, empty},    32'd1);
        check("t5_rst_busy",  {31'd0, busy},     32'd0);
        exp_q.delete();
        s0 = n_starts;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_start", n_starts - s0, 32'd0);
        auto_done = 1;
        push_byte(8'h3C);
        wait_idle("t5_idle");
        check("t5_one_start", n_starts - s0, 32'd1);

        // Spurious tx_done in IDLE and in LOAD.
        auto_done = 0;
        spur_cnt++;
        repeat (2) @(negedge clk);
        check("t6_idle_busy",  {31'd0, busy},     32'd0);
        check("t6_idle_start", {31'd0, tx_start}, 32'd0);
        check("t6_idle_empty", {31'd0, empty},    32'd1);
        s0 = n_starts;
        push_byte(8'hC3);
        spur_cnt++;
        @(negedge clk);
        check("t6_load_start", {31'd0, tx_start}, 32'd1);
        @(negedge clk);
        check("t6_wait_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("t6_still_wait", {31'd0, busy}, 32'd1);
        spur_cnt++;
        repeat (2) @(negedge clk);
        check("t6_done_busy", {31'd0, busy}, 32'd0);
        check("t6_starts", n_starts - s0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_fifo
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer between the host/application logic and the UART transmit path. Accepts bytes at system-clock rate into a circular FIFO, then launches them one at a time into the UART transmitter. Each launch is a one-cycle `tx_start` with stable `data_out`; the block waits for the transmitter's `tx_done` before launching the next byte. Its `tx_start`/`data_out` outputs connect directly to `tx_start`/`data_in` of the UART top, and that block's `tx_done` returns here.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ADDR_W`, 4: pointer width, equal to log2(`DEPTH`).

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `wr_en` in 1: push request, sampled on the rising edge.
- `wr_data` in 8: byte to push.
- `full` out 1: high when `count == DEPTH`.
- `empty` out 1: high when `count == 0`.
- `count` out `ADDR_W+1`: number of bytes stored. Excludes the byte currently in flight.
- `overflow` out 1: sticky; set when `wr_en` is high while `full` is high.
- `clr_ovf` in 1: clears `overflow`.
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `data_out` out 8: byte being transmitted. Held stable from the `tx_start` cycle until `tx_done`.
- `tx_done` in 1: one-cycle completion pulse from the transmitter.
- `busy` out 1: high in states LOAD and WAIT.

## Operation
- Storage: `DEPTH`×8 array, write pointer `wr_ptr` and read pointer `rd_ptr`, each `ADDR_W` bits. Pointers wrap modulo `DEPTH` by natural overflow. `count` is a separate register.
- Push: on an edge with `wr_en=1` and `full=0`, write `mem[wr_ptr]<=wr_data`, then `wr_ptr++`.
  - A push while full is dropped. The memory and `wr_ptr` are unchanged, and `overflow<=1`.
  - The full check uses the registered `count`. A pop in the same cycle does not make room for a push.
- FSM states:
  - IDLE → LOAD when `count!=0`. On this edge: `data_out<=mem[rd_ptr]`, `rd_ptr++`, `tx_start<=1`.
  - LOAD → WAIT, unconditionally. On this edge `tx_start<=0`.
  - WAIT → IDLE on `tx_done=1`.
- `tx_done` is ignored in IDLE and LOAD.
- Push and pop on the same edge: `count` is unchanged, and both pointers advance.
- `clr_ovf` and an overflowing push on the same edge: set wins, so `overflow` stays 1.
- `data_out` keeps its last value in IDLE.
- Reset values:
  - Outputs: `tx_start=0`, `data_out=8'h00`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `busy=0`.
  - Internal: state IDLE, both pointers 0.
  - Memory contents are not reset.
- Reset mid-operation discards all queued bytes and any in-flight byte. The transmitter shares the reset line, so it aborts too.

## Timing
- All outputs are registered. `full`, `empty` and `busy` are decoded directly from registers.
- Push with FIFO empty and FSM idle:
  - `wr_en` sampled at edge E0.
  - `count=1` after E0.
  - Pop at E1: `tx_start=1` and `data_out` valid during the E1–E2 cycle, `count=0`.
  - `tx_start=0` after E2.
  - Latency from `wr_en` to `tx_start` is two cycles.
- Back-to-back transmission: `tx_done` sampled at edge Ed gives IDLE after Ed. If `count!=0`, the next pop occurs at Ed+1, so `tx_start` is high in the cycle after Ed+1. The gap is one idle cycle.
- Sustained push rate is one byte per clock until full.

## Structure
- Shared package `uart_pkg`:
  - `DATA_W=8`.
  - FSM state enum with encodings IDLE=2'd0, LOAD=2'd1, WAIT=2'd2.
  - The same package holds UART-wide constants (`CLK_FREQ`, `BAUD_RATE`).
- One sub-module, `fifo_mem`: the `DEPTH`×8 array with a synchronous write port and a combinational read port. Pointers, count and FSM stay in `uart_tx_fifo`.

## Test plan
- Single byte:
  - Stimulus: push `8'hA5` into the empty FIFO.
  - Response: `tx_start` is high for exactly one cycle, 2 cycles after the push, with `data_out=8'hA5`; `count` goes 0→1→0; `busy` stays high until the `tx_done` pulse, then drops.
- Burst and wrap-around:
  - Stimulus: push 20 bytes `8'h00`–`8'h13` over two rounds, so pointers wrap, and model `tx_done` 10 cycles after each `tx_start`.
  - Response: exactly 20 `tx_start` pulses with `data_out` in order 00…13; no loss or duplication; `count` ends at 0.
- Full and overflow:
  - Stimulus: hold `tx_done` low and push 18 bytes.
  - Response:
    - The first byte goes in flight.
    - `count` reaches 16 and `full=1` after the 17th push.
    - The 18th push is dropped and `overflow=1`.
    - `clr_ovf` clears `overflow`.
    - Released `tx_done` pulses drain bytes 2–17 in order.
- Simultaneous push/pop with `count=5` in IDLE:
  - Stimulus: push on the same edge as the pop.
  - Response: `count` stays 5; the popped byte is the oldest one.
- Reset mid-transmission:
  - Stimulus: in WAIT with `count=3`, drive `reset=0` asynchronously, between clock edges.
  - Response:
    - Outputs go to reset values immediately.
    - After release, no `tx_start` occurs until a new push.
    - A new push of `8'h3C` transmits `8'h3C`, not stale data.
- Spurious `tx_done`:
  - Stimulus: pulse `tx_done` in IDLE and in LOAD.
  - Response: the state is unaffected, and WAIT still requires a later `tx_done`.
